// File: rtl/btb_predictor_pkg.sv
// Shared types and defaults for the branch target buffer.
// The legacy single-bit entry layout is kept so existing users still compile.
package btb_predictor_pkg;

  typedef enum logic {
    BTB_INIT,
    BTB_READY
  } btb_state_t;

  localparam int BTB_CNT_W_DEF   = 2;
  localparam int BTB_ENTRIES_DEF = 16;

  // Original one-bit-direction entry: valid, tag, target address, taken.
  typedef struct packed {
    logic        v;
    logic [5:0]  tag;
    logic [31:0] ta;
    logic        t;
  } CACHE_BRANCH;

endpackage

// File: rtl/btb_sat_counter.sv
// CNT_W-bit saturating up/down counter step: +1 on taken, -1 on not taken,
// clamped at all-ones and at zero.
module btb_sat_counter
  import btb_predictor_pkg::*;
#(
  parameter int CNT_W = BTB_CNT_W_DEF
) (
  input  logic [CNT_W-1:0] cnt,
  input  logic             taken,
  output logic [CNT_W-1:0] next_cnt
);

  // NOTE: next_cnt is given a default before any branch so no latch is inferred.
  always_comb begin
    next_cnt = cnt;
    if (taken) begin
      if (cnt != '1) next_cnt = cnt + CNT_W'(1);
    end else begin
      if (cnt != '0) next_cnt = cnt - CNT_W'(1);
    end
  end

endmodule

// File: rtl/btb_predictor.sv
// Direct-mapped branch target buffer with saturating direction counters.
// Looked up with the fetch PC (1-cycle registered result), trained from MEM.
module btb_predictor
  import btb_predictor_pkg::*;
#(
  parameter int ENTRIES = BTB_ENTRIES_DEF,
  parameter int TAG_W   = 6,
  parameter int CNT_W   = BTB_CNT_W_DEF,
  parameter int XLEN    = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush_i,
  input  logic            lookup_valid_i,
  input  logic [XLEN-1:0] lookup_pc_i,
  output logic            pred_hit_o,
  output logic            pred_taken_o,
  output logic [XLEN-1:0] pred_target_o,
  input  logic            upd_valid_i,
  input  logic [XLEN-1:0] upd_pc_i,
  input  logic            upd_taken_i,
  input  logic [XLEN-1:0] upd_target_i,
  output logic            ready_o
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_LO = IDX_W + 2;
  localparam int TAG_HI = IDX_W + TAG_W + 1;
  localparam logic [CNT_W-1:0] CNT_WEAK_TAKEN = CNT_W'(1) << (CNT_W - 1);

  typedef struct packed {
    logic             v;
    logic [TAG_W-1:0] tag;
    logic [XLEN-1:0]  ta;
    logic [CNT_W-1:0] cnt;
  } entry_t;

  entry_t           r_mem [ENTRIES];
  btb_state_t       r_state;
  logic [IDX_W-1:0] r_ptr;
  logic             r_hit;
  logic             r_taken;
  logic [XLEN-1:0]  r_target;

  logic             w_ready;
  logic [IDX_W-1:0] w_lk_idx;
  logic [TAG_W-1:0] w_lk_tag;
  entry_t           w_lk_entry;
  logic             w_lk_hit;
  logic [IDX_W-1:0] w_up_idx;
  logic [TAG_W-1:0] w_up_tag;
  entry_t           w_up_entry;
  logic             w_up_hit;
  logic [CNT_W-1:0] w_next_cnt;
  entry_t           w_up_wdata;
  logic             w_upd_we;
  logic             w_unused_pc;

  assign w_ready = (r_state == BTB_READY);

  // Lookup side: only meaningful once the sweep has finished.
  assign w_lk_idx   = lookup_pc_i[IDX_W+1:2];
  assign w_lk_tag   = lookup_pc_i[TAG_HI:TAG_LO];
  assign w_lk_entry = r_mem[w_lk_idx];
  assign w_lk_hit   = w_ready && lookup_valid_i && w_lk_entry.v
                      && (w_lk_entry.tag == w_lk_tag);

  assign w_up_idx   = upd_pc_i[IDX_W+1:2];
  assign w_up_tag   = upd_pc_i[TAG_HI:TAG_LO];
  assign w_up_entry = r_mem[w_up_idx];
  assign w_up_hit   = w_up_entry.v && (w_up_entry.tag == w_up_tag);

  btb_sat_counter #(
    .CNT_W (CNT_W)
  ) u_sat_counter (
    .cnt      (w_up_entry.cnt),
    .taken    (upd_taken_i),
    .next_cnt (w_next_cnt)
  );

  // A not-taken miss writes nothing; a taken miss allocates weakly taken.
  assign w_upd_we = w_ready && upd_valid_i && !rst && !flush_i
                    && (w_up_hit || upd_taken_i);

  always_comb begin
    w_up_wdata = w_up_entry;
    if (w_up_hit) begin
      w_up_wdata.cnt = w_next_cnt;
      if (upd_taken_i) w_up_wdata.ta = upd_target_i;
    end else begin
      w_up_wdata.v   = 1'b1;
      w_up_wdata.tag = w_up_tag;
      w_up_wdata.ta  = upd_target_i;
      w_up_wdata.cnt = CNT_WEAK_TAKEN;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      r_state <= BTB_INIT;
      r_ptr   <= '0;
    end else begin
      case (r_state)
        BTB_INIT: begin
          r_ptr <= r_ptr + IDX_W'(1);
          if (r_ptr == IDX_W'(ENTRIES - 1)) r_state <= BTB_READY;
        end
        BTB_READY: r_state <= BTB_READY;
        default:   r_state <= BTB_INIT;
      endcase
    end
  end

  // NOTE: the entry array has no reset; the INIT sweep clears V one entry per cycle.
  always_ff @(posedge clk) begin
    if (r_state == BTB_INIT) begin
      r_mem[r_ptr].v <= 1'b0;
    end else if (w_upd_we) begin
      r_mem[w_up_idx] <= w_up_wdata;
    end
  end

  // Registered prediction; reads pre-update contents when indices collide.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hit    <= 1'b0;
      r_taken  <= 1'b0;
      r_target <= '0;
    end else begin
      r_hit    <= w_lk_hit;
      r_taken  <= w_lk_hit && w_lk_entry.cnt[CNT_W-1];
      r_target <= w_lk_hit ? w_lk_entry.ta : '0;
    end
  end

  assign pred_hit_o    = r_hit;
  assign pred_taken_o  = r_taken;
  assign pred_target_o = r_target;
  assign ready_o       = w_ready;

  assign w_unused_pc = ^{lookup_pc_i[XLEN-1:TAG_HI+1], lookup_pc_i[1:0],
                         upd_pc_i[XLEN-1:TAG_HI+1], upd_pc_i[1:0]};

endmodule

// File: tb/tb_btb_predictor.sv
// Bench for btb_predictor: a behavioural model checked every cycle, plus
// directed sequences with hand-computed literal expectations.
module tb_btb_predictor;

  localparam int ENTRIES = 16;
  localparam int TAG_W   = 6;
  localparam int CNT_W   = 2;
  localparam int XLEN    = 32;
  localparam int CMAX    = (1 << CNT_W) - 1;
  localparam int CHALF   = 1 << (CNT_W - 1);

  logic        clk = 1'b0;
  logic        rst;
  logic        flush_i;
  logic        lookup_valid_i;
  logic [31:0] lookup_pc_i;
  logic        pred_hit_o;
  logic        pred_taken_o;
  logic [31:0] pred_target_o;
  logic        upd_valid_i;
  logic [31:0] upd_pc_i;
  logic        upd_taken_i;
  logic [31:0] upd_target_i;
  logic        ready_o;

  int checks   = 0;
  int failures = 0;

  btb_predictor #(
    .ENTRIES (ENTRIES),
    .TAG_W   (TAG_W),
    .CNT_W   (CNT_W),
    .XLEN    (XLEN)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .flush_i        (flush_i),
    .lookup_valid_i (lookup_valid_i),
    .lookup_pc_i    (lookup_pc_i),
    .pred_hit_o     (pred_hit_o),
    .pred_taken_o   (pred_taken_o),
    .pred_target_o  (pred_target_o),
    .upd_valid_i    (upd_valid_i),
    .upd_pc_i       (upd_pc_i),
    .upd_taken_i    (upd_taken_i),
    .upd_target_i   (upd_target_i),
    .ready_o        (ready_o)
  );

  initial forever #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: table of entries, sweep modelled as a countdown of
  // cycles during which the buffer is unusable.
  bit          m_v   [ENTRIES];
  int unsigned m_tag [ENTRIES];
  logic [31:0] m_ta  [ENTRIES];
  int          m_cnt [ENTRIES];
  int          sweep_left = ENTRIES;
  bit          chk_en = 1'b0;
  logic        e_hit = 1'b0, e_taken = 1'b0, e_ready = 1'b0;
  logic [31:0] e_tgt = '0;

  task automatic model_step();
    int unsigned idx, tag;
    bit rdy;
    if (rst) begin
      e_hit = 0; e_taken = 0; e_tgt = 0;
      sweep_left = ENTRIES;
      for (int i = 0; i < ENTRIES; i++) m_v[i] = 0;
      chk_en = 1;
    end else begin
      rdy = (sweep_left == 0);
      e_hit = 0; e_taken = 0; e_tgt = 0;
      if (rdy && lookup_valid_i) begin
        idx = (lookup_pc_i / 4) % ENTRIES;
        tag = (lookup_pc_i / (4 * ENTRIES)) % (2 ** TAG_W);
        if (m_v[idx] && m_tag[idx] == tag) begin
          e_hit   = 1;
          e_taken = (m_cnt[idx] >= CHALF);
          e_tgt   = m_ta[idx];
        end
      end
      if (flush_i) begin
        sweep_left = ENTRIES;
        for (int i = 0; i < ENTRIES; i++) m_v[i] = 0;
      end else if (!rdy) begin
        sweep_left--;
      end else if (upd_valid_i) begin
        idx = (upd_pc_i / 4) % ENTRIES;
        tag = (upd_pc_i / (4 * ENTRIES)) % (2 ** TAG_W);
        if (m_v[idx] && m_tag[idx] == tag) begin
          if (upd_taken_i) begin
            m_cnt[idx] = (m_cnt[idx] == CMAX) ? CMAX : m_cnt[idx] + 1;
            m_ta[idx]  = upd_target_i;
          end else begin
            m_cnt[idx] = (m_cnt[idx] == 0) ? 0 : m_cnt[idx] - 1;
          end
        end else if (upd_taken_i) begin
          m_v[idx]   = 1;
          m_tag[idx] = tag;
          m_ta[idx]  = upd_target_i;
          m_cnt[idx] = CHALF;
        end
      end
    end
    e_ready = (sweep_left == 0);
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      check("cyc_hit",    32'(pred_hit_o),   32'(e_hit));
      check("cyc_taken",  32'(pred_taken_o), 32'(e_taken));
      check("cyc_target", pred_target_o,     e_tgt);
      check("cyc_ready",  32'(ready_o),      32'(e_ready));
    end
  end

  task automatic look(input string nm, input logic [31:0] pc, input logic hit, input logic taken,
                      input logic [31:0] tgt);
    lookup_valid_i = 1'b1;
    lookup_pc_i    = pc;
    @(negedge clk);
    lookup_valid_i = 1'b0;
    check({nm, "_hit"},    32'(pred_hit_o),   32'(hit));
    check({nm, "_taken"},  32'(pred_taken_o), 32'(taken));
    check({nm, "_target"}, pred_target_o,     tgt);
  endtask

  task automatic upd(input logic [31:0] pc, input logic tk, input logic [31:0] tgt);
    upd_valid_i  = 1'b1;
    upd_pc_i     = pc;
    upd_taken_i  = tk;
    upd_target_i = tgt;
    @(negedge clk);
    upd_valid_i  = 1'b0;
  endtask

  // Called right after rst/flush drops: ready must stay low for 16 cycles.
  task automatic sweep_check(input string nm, input bit with_upd);
    check({nm, "_ready_c1"}, 32'(ready_o), 32'd0);
    for (int k = 1; k <= 16; k++) begin
      lookup_valid_i = 1'b1;
      lookup_pc_i    = 32'h40 + 32'(k) * 32'd4;
      if (with_upd) begin
        upd_valid_i  = 1'b1;
        upd_pc_i     = 32'h104;
        upd_taken_i  = 1'b1;
        upd_target_i = 32'h777;
      end
      @(negedge clk);
      check({nm, "_ready"},  32'(ready_o), (k == 16) ? 32'd1 : 32'd0);
      check({nm, "_hit"},    32'(pred_hit_o), 32'd0);
      check({nm, "_target"}, pred_target_o, 32'd0);
    end
    lookup_valid_i = 1'b0;
    upd_valid_i    = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; flush_i = 1'b0;
    lookup_valid_i = 1'b0; lookup_pc_i = '0;
    upd_valid_i = 1'b0; upd_pc_i = '0; upd_taken_i = 1'b0; upd_target_i = '0;
    repeat (3) @(negedge clk);
    check("rst_hit",    32'(pred_hit_o),   32'd0);
    check("rst_taken",  32'(pred_taken_o), 32'd0);
    check("rst_target", pred_target_o,     32'd0);
    check("rst_ready",  32'(ready_o),      32'd0);
    rst = 1'b0;
    sweep_check("reset", 1'b0);

    // Same-cycle update and lookup on an empty entry: lookup sees old contents.
    upd_valid_i = 1'b1; upd_pc_i = 32'h80; upd_taken_i = 1'b1; upd_target_i = 32'h300;
    lookup_valid_i = 1'b1; lookup_pc_i = 32'h80;
    @(negedge clk);
    upd_valid_i = 1'b0; lookup_valid_i = 1'b0;
    check("same_cyc_hit", 32'(pred_hit_o), 32'd0);
    look("after_same_cyc", 32'h80, 1'b1, 1'b1, 32'h300);

    // Allocate 0x40 (same index as 0x80, overwrites it), counter weakly taken.
    upd(32'h40, 1'b1, 32'h100);
    look("alloc40", 32'h40, 1'b1, 1'b1, 32'h100);
    look("evict80", 32'h80, 1'b0, 1'b0, 32'h0);

    // Down to 00 with saturation; not-taken leaves the target alone.
    upd(32'h40, 1'b0, 32'h999);
    upd(32'h40, 1'b0, 32'h999);
    upd(32'h40, 1'b0, 32'h999);
    look("cnt00", 32'h40, 1'b1, 1'b0, 32'h100);
    upd(32'h40, 1'b1, 32'h100);
    look("cnt01", 32'h40, 1'b1, 1'b0, 32'h100);
    upd(32'h40, 1'b1, 32'h100);
    look("cnt10", 32'h40, 1'b1, 1'b1, 32'h100);
    upd(32'h40, 1'b1, 32'h100);
    upd(32'h40, 1'b1, 32'h180);
    look("cnt11", 32'h40, 1'b1, 1'b1, 32'h180);
    upd(32'h40, 1'b0, 32'h999);
    look("cnt11_dn1", 32'h40, 1'b1, 1'b1, 32'h180);
    upd(32'h40, 1'b0, 32'h999);
    look("cnt11_dn2", 32'h40, 1'b1, 1'b0, 32'h180);

    // Aliasing: 0x440 shares index 0 with 0x40, different tag.
    look("alias_miss", 32'h440, 1'b0, 1'b0, 32'h0);
    upd(32'h440, 1'b1, 32'h200);
    look("alias_alloc", 32'h440, 1'b1, 1'b1, 32'h200);
    look("alias_evict", 32'h40, 1'b0, 1'b0, 32'h0);
    upd(32'h800, 1'b0, 32'h55);
    look("nt_miss_nowrite", 32'h440, 1'b1, 1'b1, 32'h200);
    look("nt_miss_absent", 32'h800, 1'b0, 1'b0, 32'h0);

    // Three valid entries, then flush; updates during the sweep are dropped.
    upd(32'h104, 1'b1, 32'h400);
    upd(32'h208, 1'b1, 32'h500);
    look("pre_flush_a", 32'h440, 1'b1, 1'b1, 32'h200);
    look("pre_flush_b", 32'h104, 1'b1, 1'b1, 32'h400);
    look("pre_flush_c", 32'h208, 1'b1, 1'b1, 32'h500);
    flush_i = 1'b1;
    @(negedge clk);
    flush_i = 1'b0;
    sweep_check("flush", 1'b1);
    look("post_flush_a", 32'h440, 1'b0, 1'b0, 32'h0);
    look("post_flush_b", 32'h104, 1'b0, 1'b0, 32'h0);
    look("post_flush_c", 32'h208, 1'b0, 1'b0, 32'h0);

    // Reset arriving at sweep cycle 5 restarts the full sweep.
    upd(32'h104, 1'b1, 32'h400);
    flush_i = 1'b1;
    @(negedge clk);
    flush_i = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    sweep_check("rst_mid", 1'b0);
    look("post_rst", 32'h104, 1'b0, 1'b0, 32'h0);

    // Mixed traffic with colliding indices, checked by the per-cycle model.
    for (int k = 0; k < 80; k++) begin
      lookup_valid_i = (k % 5) != 4;
      lookup_pc_i    = 32'((k * 13) % 40) * 32'd4;
      upd_valid_i    = (k % 4) != 3;
      upd_pc_i       = 32'((k * 7) % 40) * 32'd4;
      upd_taken_i    = (k % 3) != 0;
      upd_target_i   = 32'h1000 + 32'(k) * 32'd16;
      @(negedge clk);
    end
    lookup_valid_i = 1'b0;
    upd_valid_i    = 1'b0;
    repeat (3) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/btb_predictor.md
# btb_predictor

Parametrised direct-mapped branch target buffer with N-bit saturating direction counters, generalising the single-bit `CACHE_BRANCH` entry (V, TAG, TA, T). It sits beside the fetch stage and is looked up with the fetch PC. It returns a registered taken/target prediction one cycle later. It is trained from the MEM stage with resolved branch/jump outcomes. It self-clears after reset and on flush through a sweep state machine.

## Interface
- `ENTRIES`, 16: number of entries; power of two, ≥2; `IDX_W = $clog2(ENTRIES)`.
- `TAG_W`, 6: tag bits stored per entry.
- `CNT_W`, 2: direction counter width, 1..4.
- `XLEN`, 32: PC/target width.
- `clk` in 1: single clock, all state on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `flush_i` in 1: invalidate all entries (restart sweep).
- `lookup_valid_i` in 1: fetch lookup request.
- `lookup_pc_i` in XLEN: fetch PC.
- `pred_hit_o` out 1: registered, tag match on valid entry.
- `pred_taken_o` out 1: registered, hit AND counter MSB set.
- `pred_target_o` out XLEN: registered, stored target (0 when not hit).
- `upd_valid_i` in 1: training request from MEM.
- `upd_pc_i` in XLEN: PC of resolved branch.
- `upd_taken_i` in 1: resolved direction.
- `upd_target_i` in XLEN: resolved target.
- `ready_o` out 1: high in BTB_READY.

## Operation
- Index = `pc[IDX_W+1:2]`; tag = `pc[IDX_W+TAG_W+1:IDX_W+2]`; bits [1:0] ignored.
- Entry = {V, TAG[TAG_W], TA[XLEN], CNT[CNT_W]}.
- FSM states:
  - BTB_INIT: sweep pointer clears V of one entry per cycle, 0..ENTRIES-1; on the last index → BTB_READY.
  - BTB_READY: normal operation; `flush_i` → BTB_INIT with pointer = 0.
- `rst` or `flush_i` in any state (including mid-sweep) restarts the sweep at 0. `rst` has priority over everything.
- Lookup (READY, `lookup_valid_i`): next cycle `pred_hit_o` = V & tag match; `pred_taken_o` = hit & CNT[CNT_W-1]; `pred_target_o` = TA if hit else 0.
- Lookup while not READY, or `lookup_valid_i`=0: outputs next cycle are all 0.
- Update (READY only; ignored in INIT):
  - Hit: CNT saturating +1 if taken, −1 if not taken. Saturates at all-ones and at 0. TA ← `upd_target_i` only when taken.
  - Miss and taken: allocate (overwrite) with V=1, TAG, TA=target, CNT = `1<<(CNT_W-1)` (weakly taken).
  - Miss and not taken: no write.
- Same-cycle lookup and update to the same index: the lookup returns pre-update contents (no bypass).

## Timing
- Reset values: `pred_hit_o`=0, `pred_taken_o`=0, `pred_target_o`=0, `ready_o`=0, FSM=BTB_INIT, pointer=0.
- Sweep duration: ready rises ENTRIES cycles after `rst`/`flush_i` deasserts.
- Lookup latency: 1 cycle, fully pipelined; one lookup per cycle.
- Update: written at the clock edge; visible to a lookup issued on the following cycle.
- Counter arithmetic is CNT_W-bit unsigned with explicit saturation; no wrap.

## Structure
- Shared package additions:
  - `btb_state_t` enum {BTB_INIT, BTB_READY}.
  - Constants `BTB_CNT_W_DEF=2`, `BTB_ENTRIES_DEF=16`.
- The entry struct depends on parameters, so it is declared inside the module as a packed struct. `CACHE_BRANCH` remains for legacy users.
- Sub-module `btb_sat_counter`: CNT_W-bit combinational saturating inc/dec (inputs cnt, taken; output next_cnt). It is instantiated once on the update path.
- Storage is a flop array with a synchronous write port and a registered read port.

## Test plan
- Reset, then hold 16 cycles: `ready_o`=0 for cycles 1–16 and goes 1 at cycle 17. A lookup of any PC during cycles 1–16 returns hit=0, taken=0, target=0.
- Update 0x0000_0040 taken → target 0x0000_0100, then lookup 0x40: hit=1, taken=1, target=0x100, CNT=2'b10.
- Same PC, not taken ×3: CNT 10→01→00→00 (saturates). Lookup gives hit=1, taken=0, target still 0x100. Then taken ×4: CNT saturates at 11.
- Aliasing: train 0x40, then lookup 0x440 (same index, different tag): hit=0. Update 0x440 taken → 0x200 overwrites; lookup 0x40 then misses.
- Same-cycle update 0x80 taken → 0x300 and lookup 0x80 on empty BTB: that lookup gives hit=0; the next lookup gives hit=1, target=0x300.
- `flush_i` pulse with 3 valid entries: `ready_o`=0 for 16 cycles and updates are ignored; all lookups then miss. `rst` asserted at sweep cycle 5 restarts the full 16-cycle sweep.
